// File: rtl/vga_multi_ball_renderer.sv
// Multi-ball bouncing renderer: vblank position-update FSM plus a 2-stage pixel pipeline.
// Define SHADOW_EN to draw a grey shadow ring of SHADOW_MARGIN pixels around every ball.
module vga_multi_ball_renderer #(
    parameter int unsigned NUM_BALLS     = 4,
    parameter int unsigned BALL_RADIUS   = 12,
    parameter int unsigned SHADOW_MARGIN = 4,
    parameter int unsigned SCREEN_W      = 640,
    parameter int unsigned SCREEN_H      = 480,
    parameter logic [5:0]  BG_COLOR      = 6'b00_00_10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] speed,
    input  logic       pause,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_done
);

    localparam int unsigned       R        = BALL_RADIUS;
    localparam logic signed [10:0] LO      = 11'(R);
    localparam logic signed [10:0] X_HI    = 11'(SCREEN_W - 1 - R);
    localparam logic signed [10:0] Y_HI    = 11'(SCREEN_H - 1 - R);
    localparam logic [20:0]       R2       = 21'(R * R);
    localparam logic [2:0]        LAST_IDX = 3'(NUM_BALLS - 1);
    localparam logic [47:0]       PALETTE  = {6'b101010, 6'b110000, 6'b001111, 6'b111100,
                                              6'b000011, 6'b110011, 6'b001100, 6'b111000};
`ifdef SHADOW_EN
    localparam logic [20:0]       RS2      = 21'((R + SHADOW_MARGIN) * (R + SHADOW_MARGIN));
`endif

    // Reject illegal configurations at elaboration time.
    if (NUM_BALLS < 1 || NUM_BALLS > 8 || 2 * (R + SHADOW_MARGIN) >= SCREEN_H) begin : g_param_check
        $error("vga_multi_ball_renderer: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_e;

    state_e     state_q;
    logic [2:0] idx_q;
    logic       frame_done_q;
    logic [9:0] bx_q  [8];
    logic [9:0] by_q  [8];
    logic       bxd_q [8];
    logic       byd_q [8];
    logic [10:0] nx_d;
    logic [10:0] ny_d;

    // One axis step: returns {dir, pos}; the low clamp is tested first so it wins.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [2:0] spd, input logic signed [10:0] hi);
        logic signed [10:0] cur;
        logic signed [10:0] np;
        cur = $signed({1'b0, pos});
        np  = dir ? cur + $signed({8'd0, spd}) : cur - $signed({8'd0, spd});
        if (np < LO)      axis_step = {1'b1, 10'(LO)};
        else if (np > hi) axis_step = {1'b0, 10'(hi)};
        else              axis_step = {dir, np[9:0]};
    endfunction

    always_comb begin
        nx_d = axis_step(bx_q[idx_q], bxd_q[idx_q], speed, X_HI);
        ny_d = axis_step(by_q[idx_q], byd_q[idx_q], speed, Y_HI);
    end

    // Update FSM walks one ball per clock, starting on the first vblank line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                bx_q[i]  <= 10'(2 * R + 3 * R * i);
                by_q[i]  <= 10'(SCREEN_H / 2);
                bxd_q[i] <= ~i[0];
                byd_q[i] <= i[0];
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hpos == 10'd0 && vpos == 10'(SCREEN_H)) begin
                        state_q <= S_UPDATE;
                        idx_q   <= 3'd0;
                    end
                end
                S_UPDATE: begin
                    if (!pause) begin
                        bx_q[idx_q]  <= nx_d[9:0];
                        bxd_q[idx_q] <= nx_d[10];
                        by_q[idx_q]  <= ny_d[9:0];
                        byd_q[idx_q] <= ny_d[10];
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q      <= S_DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic signed [10:0] dx_q [NUM_BALLS];
    logic signed [10:0] dy_q [NUM_BALLS];
    logic               on_q;
    logic [1:0]         hs_q;
    logic [1:0]         vs_q;
    logic [5:0]         rgb_q;
    logic [5:0]         rgb_d;

    function automatic logic [20:0] dist2(input logic signed [10:0] a, input logic signed [10:0] b);
        logic signed [21:0] pa;
        logic signed [21:0] pb;
        pa = 22'(a) * 22'(a);
        pb = 22'(b) * 22'(b);
        dist2 = 21'(pa) + 21'(pb);
    endfunction

    // Stage 1: per-ball offsets and delayed display_on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            on_q <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                dx_q[i] <= 11'sd0;
                dy_q[i] <= 11'sd0;
            end
        end else begin
            on_q <= display_on;
            for (int i = 0; i < NUM_BALLS; i++) begin
                dx_q[i] <= $signed({1'b0, hpos}) - $signed({1'b0, bx_q[i]});
                dy_q[i] <= $signed({1'b0, vpos}) - $signed({1'b0, by_q[i]});
            end
        end
    end

    // Stage 2 colour select: lowest-index ball wins.
    always_comb begin
        logic found;
`ifdef SHADOW_EN
        logic shadow;
        shadow = 1'b0;
`endif
        found = 1'b0;
        rgb_d = BG_COLOR;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!found && dist2(dx_q[i], dy_q[i]) <= R2) begin
                found = 1'b1;
                rgb_d = PALETTE[6*i +: 6];
            end
`ifdef SHADOW_EN
            if (dist2(dx_q[i], dy_q[i]) <= RS2) shadow = 1'b1;
`endif
        end
`ifdef SHADOW_EN
        if (!found && shadow) rgb_d = 6'b01_01_01;
`endif
        if (!on_q) rgb_d = 6'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= 6'd0;
            hs_q  <= 2'd0;
            vs_q  <= 2'd0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= {hs_q[0], hsync_in};
            vs_q  <= {vs_q[0], vsync_in};
        end
    end

    assign rgb_out    = rgb_q;
    assign hsync_out  = hs_q[1];
    assign vsync_out  = vs_q[1];
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_multi_ball_renderer.sv
// Scoreboard bench for vga_multi_ball_renderer against a frame-level ball model.
module tb_vga_multi_ball_renderer;

    localparam int NB = 4;
    localparam int R  = 12;
    localparam int SM = 4;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam logic [5:0] BG = 6'b00_00_10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [2:0] speed = '0;
    logic       pause = 1'b0;
    logic [5:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;
    logic       frame_done;

    vga_multi_ball_renderer dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed), .pause(pause),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t sbq[$];
    int   fdq[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    logic [5:0] pal [8] = '{6'b111000, 6'b001100, 6'b110011, 6'b000011,
                            6'b111100, 6'b001111, 6'b110000, 6'b101010};
    int mx [NB];
    int my [NB];
    bit mxd [NB];
    bit myd [NB];

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]  = 2 * R + 3 * R * i;
            my[i]  = H / 2;
            mxd[i] = (i % 2) == 0;
            myd[i] = (i % 2) == 1;
        end
    endfunction

    function automatic void step_axis(inout int p, inout bit d, input int spd, input int hi);
        int np;
        np = d ? p + spd : p - spd;
        if (np < R) begin
            p = R; d = 1'b1;
        end else if (np > hi) begin
            p = hi; d = 1'b0;
        end else begin
            p = np;
        end
    endfunction

    function automatic void model_frame(input int spd, input bit pz);
        int p;
        bit d;
        if (pz) return;
        for (int i = 0; i < NB; i++) begin
            p = mx[i]; d = mxd[i]; step_axis(p, d, spd, W - 1 - R); mx[i] = p; mxd[i] = d;
            p = my[i]; d = myd[i]; step_axis(p, d, spd, H - 1 - R); my[i] = p; myd[i] = d;
        end
    endfunction

    function automatic logic [5:0] model_pixel(input int hp, input int vp, input bit on);
        int d2;
`ifdef SHADOW_EN
        bit sh;
        sh = 1'b0;
`endif
        if (!on) return 6'd0;
        for (int i = 0; i < NB; i++) begin
            d2 = (hp - mx[i]) * (hp - mx[i]) + (vp - my[i]) * (vp - my[i]);
            if (d2 <= R * R) return pal[i % 8];
`ifdef SHADOW_EN
            if (d2 <= (R + SM) * (R + SM)) sh = 1'b1;
`endif
        end
`ifdef SHADOW_EN
        if (sh) return 6'b01_01_01;
`endif
        return BG;
    endfunction

    // Monitor: compares every output that falls due this cycle, plus frame_done each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_fd;
            exp_t e;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                checks += 3;
                if (e.due != cyc || rgb_out !== e.rgb) begin
                    failures++;
                    $display("FAIL rgb cyc=%0d due=%0d got=%b exp=%b", cyc, e.due, rgb_out, e.rgb);
                end
                if (hsync_out !== e.hs) begin
                    failures++;
                    $display("FAIL hsync cyc=%0d got=%b exp=%b", cyc, hsync_out, e.hs);
                end
                if (vsync_out !== e.vs) begin
                    failures++;
                    $display("FAIL vsync cyc=%0d got=%b exp=%b", cyc, vsync_out, e.vs);
                end
            end
            exp_fd = 1'b0;
            if (fdq.size() > 0 && fdq[0] == cyc) begin
                exp_fd = 1'b1;
                void'(fdq.pop_front());
            end
            checks++;
            if (frame_done !== exp_fd) begin
                failures++;
                $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd);
            end
        end
    end

    task automatic drive(input int hp, input int vp, input bit on, input bit hs, input bit vs,
                         input bit rst);
        exp_t e;
        @(negedge clk);
        rst_n      = rst;
        hpos       = 10'(hp);
        vpos       = 10'(vp);
        display_on = on;
        hsync_in   = hs;
        vsync_in   = vs;
        e.due = cyc + 2;
        e.rgb = model_pixel(hp, vp, on);
        e.hs  = hs;
        e.vs  = vs;
        sbq.push_back(e);
    endtask

    task automatic probe(input int hp, input int vp, input bit on);
        int h;
        int v;
        h = hp < 0 ? 0 : (hp > 799 ? 799 : hp);
        v = vp < 0 ? 0 : (vp > H - 1 ? H - 1 : vp);
        drive(h, v, on, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
    endtask

    // Single-cycle vblank trigger, optional reset on the second update cycle, then idle.
    task automatic frame_update(input bit do_reset);
        drive(0, H, 1'b0, 1'b0, 1'b0, 1'b1);
        fdq.push_back(cyc + 1 + NB);
        model_frame(int'(speed), pause);
        if (do_reset) begin
            drive(1, H, 1'b0, 1'b0, 1'b0, 1'b1);
            drive(1, H, 1'b0, 1'b0, 1'b0, 1'b0);
            model_reset();
            void'(fdq.pop_back());
        end
        for (int k = 0; k < NB + 4; k++) drive(1, H, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic probe_frame();
        int b;
        for (int i = 0; i < NB; i++) probe(mx[i], my[i], 1'b1);
        probe(400, 100, 1'b1);
        for (int k = 0; k < 6 * NB; k++) begin
            b = int'($urandom_range(0, NB - 1));
            probe(mx[b] + int'($urandom_range(0, 2 * (R + 6))) - (R + 6),
                  my[b] + int'($urandom_range(0, 2 * (R + 6))) - (R + 6),
                  ($urandom % 8) != 0);
        end
        for (int k = 0; k < 4; k++)
            probe(int'($urandom_range(0, 799)), int'($urandom_range(0, H - 1)), 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (rgb_out !== 6'd0) begin
            failures++; $display("FAIL reset_rgb got=%b exp=000000", rgb_out);
        end
        if (hsync_out !== 1'b0) begin
            failures++; $display("FAIL reset_hsync got=%b exp=0", hsync_out);
        end
        if (vsync_out !== 1'b0) begin
            failures++; $display("FAIL reset_vsync got=%b exp=0", vsync_out);
        end
        if (frame_done !== 1'b0) begin
            failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
        mon_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            case (f)
                0:       begin speed = 3'd2; pause = 1'b0; end
                1, 2, 3: begin speed = 3'd5; pause = 1'b1; end
                4:       begin speed = 3'd0; pause = 1'b0; end
                5:       begin speed = 3'd5; pause = 1'b0; end
                default: begin
                    speed = ($urandom % 4 == 0) ? 3'($urandom_range(0, 7)) : 3'd7;
                    pause = ($urandom % 6 == 0);
                end
            endcase
            probe_frame();
            frame_update(f == 5);
        end
        probe_frame();
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        checks += 2;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        if (fdq.size() != 0) begin
            failures++; $display("FAIL frame_done_drain got=%0d exp=0", fdq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
